// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory bus initiator.
//   mbm_state_t : burst FSM states
//   mbm_op_t    : burst direction, encoded exactly like the op_write pin
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } mbm_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mbm_op_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: client command/stream signals plus memory strobes and
// address of the bus initiator.
//   master modport : seen from mem_bus_master
//   slave  modport : seen from the client side
// The shared tri-state data bus is not part of this bundle. It is a plain
// inout port on the master so that it resolves directly against the
// memory's own driver on one net.
interface mem_bus_master_if #(
  parameter int DW = 16,
  parameter int AW = 8
);

  logic          start;
  logic          op_write;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;

  modport master (
    input  start, op_write, base_addr, len, wr_data, wr_valid,
    output wr_ready, rd_data, rd_valid, busy, done, mem_re, mem_we, mem_addr
  );

  modport slave (
    output start, op_write, base_addr, len, wr_data, wr_valid,
    input  wr_ready, rd_data, rd_valid, busy, done, mem_re, mem_we, mem_addr
  );

endinterface

// File: rtl/mem_burst_addr_gen.sv
// mem_burst_addr_gen: burst address counter and remaining-word counter.
//   clock, reset : system clock, async active-high reset
//   load         : capture base/len as the start of a new burst
//   step         : one word transferred; advance address, count down
//   base, len    : burst start address and word count (0..DEPTH)
//   cur_addr     : address of the word currently presented
//   last         : exactly one word remains
module mem_burst_addr_gen #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] cur_addr,
  output logic          last
);

  localparam logic [AW-1:0] ADDR_MAX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

  logic [AW:0] remain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      remain   <= '0;
    end else if (load) begin
      cur_addr <= base;
      remain   <= len;
    end else if (step) begin
      // Explicit wrap keeps the modulo-DEPTH walk correct for non-power-of-2 depths.
      cur_addr <= (cur_addr == ADDR_MAX) ? '0 : cur_addr + ADDR_ONE;
      remain   <= remain - COUNT_ONE;
    end
  end

  assign last = (remain == COUNT_ONE);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: burst initiator for the shared tri-state memory bus.
// Takes one read or write burst command (base address, length) while idle
// and streams one word per cycle with an auto-incrementing, wrapping address.
//   clock, reset : system clock, async active-high reset
//   bus          : client command/stream handshake plus mem_re/mem_we/mem_addr
//   mem_data     : tri-state data bus shared with the memory; driven only
//                  while mem_we is high
// Reads: the address is presented in one cycle and the word returned by
// the memory is registered onto rd_data/rd_valid for the following cycle.
// Writes: wr_ready is high for the whole WRITE state; a low wr_valid
// stalls the burst without timing out.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_master_if.master bus,
  inout  wire  [DW-1:0]    mem_data
);

  mbm_state_t    state;
  mbm_state_t    state_nx;
  logic          load;
  logic          step;
  logic          last;
  logic [AW-1:0] cur_addr;

  mem_burst_addr_gen #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .base    (bus.base_addr),
    .len     (bus.len),
    .cur_addr(cur_addr),
    .last    (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    load         = 1'b0;
    step         = 1'b0;
    bus.mem_re   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.wr_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          if (bus.len == '0) begin
            state_nx = DONE;
          end else if (mbm_op_t'(bus.op_write) == OP_WRITE) begin
            state_nx = WRITE;
          end else begin
            state_nx = READ;
          end
        end
      end
      READ: begin
        bus.busy   = 1'b1;
        bus.mem_re = 1'b1;
        step       = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      WRITE: begin
        bus.busy     = 1'b1;
        bus.wr_ready = 1'b1;
        bus.mem_we   = bus.wr_valid;
        step         = bus.wr_valid;
        if (bus.wr_valid && last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_addr = cur_addr;
  assign mem_data     = bus.mem_we ? bus.wr_data : 'z;

  // Read capture: the word on the bus during a READ cycle belongs to the
  // address presented in that same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= (state == READ);
      if (state == READ) begin
        bus.rd_data <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized self-checking bench for mem_bus_master.
// Each burst is planned up front: the bench knows which cycles the burst
// occupies, which addresses it must touch and which words must move. A
// single negedge process compares every output against that plan and
// against a reference copy of memory contents.
module tb_mem_bus_master;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clock;
  logic reset;
  wire  [DW-1:0] mem_data;

  mem_bus_master_if #(.DW(DW), .AW(AW)) bus ();

  mem_bus_master #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .mem_data(mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory responder: combinational read while mem_re, write on the clock edge.
  logic [DW-1:0] mem [DEPTH];
  int wr_count = 0;
  assign mem_data = bus.mem_re ? mem[bus.mem_addr] : 'z;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 37 + 5);
    forever begin
      @(posedge clock);
      if (bus.mem_we) begin
        mem[bus.mem_addr] = mem_data;
        wr_count++;
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] plan_words [$];
  logic [DW-1:0] rd_log [$];
  bit  active = 1'b0;
  bit  b_wr;
  int  b_base, b_len, b_start, b_done;
  int  nw;
  int  done_seen = -1;
  int  done_total = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(i * 37 + 5);

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the burst plan
  bit e_busy, e_done, e_re, e_wrr, e_we, e_rv;
  int k, a;
  logic [AW-1:0] prev_addr;
  bit prev_ok = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
    end else begin
      k      = cyc - b_start;
      e_busy = active && cyc >= b_start && cyc <= b_done;
      e_done = active && cyc == b_done;
      e_re   = active && !b_wr && cyc >= b_start && cyc < b_done;
      e_wrr  = active && b_wr && cyc >= b_start && cyc < b_done;
      e_we   = e_wrr && bus.wr_valid;
      e_rv   = active && !b_wr && cyc > b_start && cyc <= b_done;
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("mem_re", bus.mem_re, e_re);
      chk("mem_we", bus.mem_we, e_we);
      chk("wr_ready", bus.wr_ready, e_wrr);
      chk("rd_valid", bus.rd_valid, e_rv);
      chk("re_we_exclusive", bus.mem_re && bus.mem_we, 0);
      if (e_re) chk("rd_addr", bus.mem_addr, (b_base + k) % DEPTH);
      if (e_we && bus.mem_we && nw < plan_words.size()) begin
        a = (b_base + nw) % DEPTH;
        chk("wr_addr", bus.mem_addr, a);
        chk("wr_bus_data", mem_data, plan_words[nw]);
        ref_mem[a] = plan_words[nw];
        nw++;
      end
      if (e_rv && bus.rd_valid) chk("rd_data", bus.rd_data, ref_mem[(b_base + k - 1) % DEPTH]);
      if (bus.rd_valid) rd_log.push_back(bus.rd_data);
      if (e_done) chk("done_addr", bus.mem_addr, (b_base + b_len) % DEPTH);
      if (!e_busy && prev_ok) chk("idle_addr_stable", bus.mem_addr, prev_addr);
      if (bus.done) begin
        done_seen = cyc;
        done_total++;
      end
    end
    prev_addr = bus.mem_addr;
    prev_ok   = !reset;
  end

  // One burst: mask bit j forces a stall in the j-th WRITE cycle (j < 32);
  // beyond that rnd_stall gives random stalls. poke re-pulses start mid-burst.
  task automatic run_burst(input bit wr, input int base, input int ln, input int data0,
                           input logic [31:0] mask, input bit rnd_stall, input bit poke);
    bit pat [$];
    int acc, idx, nact;
    bit v;
    acc = 0;
    idx = 0;
    plan_words.delete();
    for (int i = 0; i < ln; i++)
      plan_words.push_back(data0 >= 0 ? 16'(data0 + i) : 16'($urandom));
    if (wr) begin
      while (acc < ln) begin
        if (pat.size() < 32) v = !mask[pat.size()];
        else v = !(rnd_stall && $urandom_range(3) == 0);
        if (pat.size() > 1000) v = 1'b1;
        pat.push_back(v);
        if (v) acc++;
      end
    end
    nact = wr ? pat.size() : ln;
    @(posedge clock); #1;
    bus.start     = 1'b1;
    bus.op_write  = wr;
    bus.base_addr = 8'(base);
    bus.len       = 9'(ln);
    bus.wr_valid  = 1'b0;
    b_wr = wr; b_base = base; b_len = ln;
    b_start = cyc + 1; b_done = b_start + nact;
    nw = 0; rd_log.delete(); done_seen = -1; active = 1'b1;
    for (int j = 0; j < nact; j++) begin
      @(posedge clock); #1;
      bus.start     = poke && j == 1;
      bus.op_write  = (poke && j == 1) ? !wr : 1'($urandom);
      bus.base_addr = 8'($urandom);
      bus.len       = (poke && j == 1) ? 9'd5 : 9'($urandom);
      if (wr) begin
        bus.wr_valid = pat[j];
        bus.wr_data  = pat[j] ? plan_words[idx] : 16'($urandom);
        if (pat[j]) idx++;
      end else begin
        bus.wr_valid = 1'($urandom);
        bus.wr_data  = 16'($urandom);
      end
    end
    @(posedge clock); #1;
    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
    @(posedge clock); #1;
    active = 1'b0;
    chk("done_cycle", done_seen, b_done);
    if (wr) chk("write_count", nw, ln);
    else    chk("read_count", rd_log.size(), ln);
  endtask

  task automatic reset_mid_burst();
    int d0, wc0;
    plan_words.delete();
    for (int i = 0; i < 8; i++) plan_words.push_back(16'(16'hD0 + i));
    @(posedge clock); #1;
    bus.start = 1'b1; bus.op_write = 1'b1; bus.base_addr = 8'h40; bus.len = 9'd8;
    b_wr = 1'b1; b_base = 'h40; b_len = 8; b_start = cyc + 1; b_done = b_start + 8;
    nw = 0; active = 1'b1; d0 = done_total; wc0 = wr_count;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = plan_words[0];
    @(posedge clock); #1;
    bus.wr_data = plan_words[1];
    #2 reset = 1'b1;
    #1;
    active = 1'b0;
    chk("rst_imm_mem_we", bus.mem_we, 0);
    chk("rst_imm_busy", bus.busy, 0);
    chk("rst_imm_wr_ready", bus.wr_ready, 0);
    @(posedge clock); #1;
    bus.wr_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_words_written", wr_count - wc0, 1);
    chk("rst_first_word", mem['h40], 16'hD0);
    chk("rst_second_untouched", mem['h41], ref_mem['h41]);
    chk("rst_no_done", done_total - d0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int wc0, d0, ln, base, r;
    bit wr;
    reset = 1'b1;
    bus.start = 1'b0; bus.op_write = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // Write burst 0x10..0x13 <- A0..A3, no stalls
    wc0 = wr_count;
    run_burst(1'b1, 'h10, 4, 'hA0, 32'h0, 1'b0, 1'b0);
    chk("wb1_latency", done_seen - b_start, 4);
    chk("wb1_we_cycles", wr_count - wc0, 4);
    for (int i = 0; i < 4; i++) chk("wb1_mem", mem['h10 + i], 'hA0 + i);

    // Read-back
    run_burst(1'b0, 'h10, 4, -1, 32'h0, 1'b0, 1'b0);
    chk("rb1_latency", done_seen - b_start, 4);
    for (int i = 0; i < 4; i++) chk("rb1_data", rd_log[i], 'hA0 + i);

    // Wrap with a two-cycle stall after the first word
    run_burst(1'b1, 'hFE, 3, 'hB0, 32'b110, 1'b0, 1'b0);
    chk("wrap_latency", done_seen - b_start, 5);
    chk("wrap_mem_fe", mem['hFE], 'hB0);
    chk("wrap_mem_ff", mem['hFF], 'hB1);
    chk("wrap_mem_00", mem['h00], 'hB2);
    chk("wrap_mem_01", mem['h01], ref_mem['h01]);
    run_burst(1'b0, 'hFE, 3, -1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk("wrap_rb_data", rd_log[i], 'hB0 + i);

    // Zero length, both directions
    wc0 = wr_count;
    run_burst(1'b1, 'h30, 0, -1, 32'h0, 1'b0, 1'b0);
    chk("zero_wr_latency", done_seen - b_start, 0);
    run_burst(1'b0, 'h30, 0, -1, 32'h0, 1'b0, 1'b0);
    chk("zero_rd_latency", done_seen - b_start, 0);
    chk("zero_no_writes", wr_count - wc0, 0);

    // start during an active burst is ignored
    d0 = done_total;
    run_burst(1'b1, 'h50, 6, 'hC0, 32'h0, 1'b0, 1'b1);
    chk("poke_one_done", done_total - d0, 1);
    chk("poke_last_word", mem['h55], 'hC5);
    run_burst(1'b0, 'h50, 6, -1, 32'h0, 1'b0, 1'b1);

    reset_mid_burst();

    // Full-depth bursts touch every word once
    base = $urandom_range(255);
    run_burst(1'b1, base, DEPTH, -1, $urandom, 1'b1, 1'b0);
    run_burst(1'b0, $urandom_range(255), DEPTH, -1, 32'h0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      r    = $urandom_range(9);
      ln   = (r == 0) ? 0 : (r == 1) ? $urandom_range(200, 256) : $urandom_range(1, 12);
      base = $urandom_range(255);
      wr   = 1'($urandom);
      run_burst(wr, base, ln, -1, $urandom, 1'b1, $urandom_range(3) == 0);
      if (wr) run_burst(1'b0, base, ln, -1, 32'h0, 1'b0, 1'b0);
    end

    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Bus initiator for the shared tri-state memory bus. It is the requesting end paired with the library `Memory` responder, which has `re`/`we` strobes, an address and a bidirectional `data` bus.
- Accepts one burst command: read or write, base address, length. It then streams words at one per cycle, auto-incrementing the address.
- Sits between client logic (game state, framebuffer fill, etc.) and the memory instance.

Parameters:
- DW, 16, data word width (matches memory DW)
- DEPTH, 256, number of memory words
- AW, $clog2(DEPTH), address width

Ports:
- clock  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- op_write  input  1  1 = write burst, 0 = read burst; sampled with start
- base_addr  input  AW  first address of the burst; sampled with start
- len  input  AW+1  number of words, 0..DEPTH; sampled with start
- wr_data  input  DW  write word from client
- wr_valid  input  1  client has a write word available
- wr_ready  output  1  master accepts wr_data this cycle
- rd_data  output  DW  registered read word
- rd_valid  output  1  rd_data is valid this cycle (one-cycle pulse per word)
- busy  output  1  high from the cycle after start through DONE
- done  output  1  one-cycle pulse at burst completion
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_data  inout  DW  tri-state data bus, shared with the memory

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; mem_re=0, mem_we=0, mem_addr=0, mem_data released ('z); rd_data=0, rd_valid=0, done=0, busy=0, wr_ready=0; address and remaining count cleared. Reset mid-burst aborts the burst; no done pulse is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, start=1:
  - latch cur_addr=base_addr and remain=len.
  - len=0 -> DONE.
  - otherwise op_write ? WRITE : READ.
- start outside IDLE is ignored. No queueing.
- READ:
  - mem_re=1, mem_addr=cur_addr; master never drives mem_data.
  - At each posedge in READ: rd_data<=mem_data, rd_valid<=1, cur_addr<=cur_addr+1, remain<=remain-1.
  - Latency: data for address A appears on rd_data/rd_valid in the cycle after A is presented. Throughput is 1 word/cycle; there is no read backpressure.
  - When remain==1 at the edge -> DONE.
- WRITE:
  - wr_ready=1 (combinational, state-based).
  - mem_we=wr_valid; mem_data driven with wr_data only while mem_we=1, otherwise 'z.
  - On an edge with wr_valid=1: cur_addr+1, remain-1; remain==1 -> DONE.
  - wr_valid=0 stalls: no write, address holds, no timeout.
- DONE: done=1 for exactly one cycle, mem_re=mem_we=0, bus released; next state IDLE.
- busy=1 in READ, WRITE and DONE.
- rd_valid outside the cycle after a READ edge = 0.
- Address wraps modulo DEPTH (e.g. DEPTH-1 -> 0). A burst of len=DEPTH touches every word exactly once.
- Invariants:
  - mem_re and mem_we are never both 1.
  - mem_data is driven only when mem_we=1.
  - mem_addr holds cur_addr in every state; its value in IDLE/DONE is don't-care but must be stable.

Decomposition:
- Package mem_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mbm_state_t
  - typedef enum logic {OP_READ=1'b0, OP_WRITE=1'b1} mbm_op_t
- One sub-module, mem_burst_addr_gen:
  - loadable address counter (wraps at DEPTH) plus remaining-count down-counter
  - outputs cur_addr and last (remain==1)
  - inputs load, step, base, len
- The FSM, bus drive and read capture live in the top.

Test Plan:
- Write burst: base=0x10, len=4, wr_valid held high, data 0xA0..0xA3 -> mem_we high 4 cycles at addr 0x10..0x13; memory holds those words; done pulses 1 cycle after last write; busy drops next cycle.
- Read-back: base=0x10, len=4 -> mem_re high 4 cycles; rd_valid high 4 consecutive cycles with rd_data 0xA0,0xA1,0xA2,0xA3; mem_data never driven by master.
- Wrap and stall:
  - write base=0xFE, len=3, wr_valid low for 2 cycles after the first word -> addresses 0xFE,0xFF,0x00 written; wr_ready stays 1; no write during the stall.
  - read-back returns the same data in order.
- Zero length and ignored start:
  - len=0 -> DONE next cycle, done pulse, no re/we activity.
  - start pulsed during an active burst -> ignored; the original burst completes unchanged.
- Reset mid-burst: assert reset during the 2nd word of a len=8 write -> immediately mem_we=0, bus 'z, busy=0; no done pulse; only the 1st word is written.
